// File: rtl/ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_resp_mux
//
// Slave-to-master response path of the shared AHB bus. The address-phase
// slave select is registered into the data phase, and the selected slave's
// HRDATA / HREADYOUT / HRESP is muxed back to the masters. Transfers that no
// slave claims are answered by the built-in default slave with a two-cycle
// ERROR response.
//
// Optional feature: define AHB_RESP_MUX_FAULT_CAPTURE_EN to build a sticky
// capture of the first unmapped HADDR. Without it, err_valid_o / err_addr_o
// are constant 0 and err_clr_i is ignored.
//
// Ports
//   clk_i                 bus clock (HCLK)
//   rst_i                 asynchronous reset, active-high (HRESET)
//   htrans_i[1:0]         shared-bus transfer type
//   haddr_i               shared-bus address (used only by fault capture)
//   hsel_<slave>_i        decoder address-phase selects
//   hrdata_<slave>_i      slave read data
//   hreadyout_<slave>_i   slave ready
//   hresp_<slave>_i       slave response, 1 = ERROR
//   hrdata_o              muxed read data to the masters
//   hready_o              global HREADY, to masters and slave HREADY inputs
//   hresp_o               muxed response
//   err_clr_i             clears the fault capture
//   err_valid_o           sticky flag: an unmapped access has been seen
//   err_addr_o            HADDR of the first unmapped access
// ---------------------------------------------------------------------------
module ahb_resp_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [1:0]            htrans_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,

  input  logic                  hsel_rom_i,
  input  logic                  hsel_sram_i,
  input  logic                  hsel_apb_i,
  input  logic                  hsel_dma_i,

  input  logic [DATA_WIDTH-1:0] hrdata_rom_i,
  input  logic [DATA_WIDTH-1:0] hrdata_sram_i,
  input  logic [DATA_WIDTH-1:0] hrdata_apb_i,
  input  logic [DATA_WIDTH-1:0] hrdata_dma_i,

  input  logic                  hreadyout_rom_i,
  input  logic                  hreadyout_sram_i,
  input  logic                  hreadyout_apb_i,
  input  logic                  hreadyout_dma_i,

  input  logic                  hresp_rom_i,
  input  logic                  hresp_sram_i,
  input  logic                  hresp_apb_i,
  input  logic                  hresp_dma_i,

  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic                  hresp_o,

  input  logic                  err_clr_i,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o
);

  // -------------------------------------------------------------------------
  // Types
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    DSEL_NONE,
    DSEL_ROM,
    DSEL_SRAM,
    DSEL_APB,
    DSEL_DMA,
    DSEL_DEF
  } dsel_e;

  typedef enum logic [1:0] {
    DEF_IDLE,
    DEF_ERR1,
    DEF_ERR2
  } def_state_e;

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  dsel_e dsel_q, dsel_d;
  logic  dsel_load;
  logic  load_def;

  // Only NONSEQ/SEQ (htrans[1]=1) carry a data phase. Overlapping selects are
  // a decoder fault; fixed priority picks one and no error is raised.
  // NOTE: every output of an always_comb gets a default on entry so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dsel_d = DSEL_NONE;
    if (htrans_i[1]) begin
      if      (hsel_rom_i)  dsel_d = DSEL_ROM;
      else if (hsel_sram_i) dsel_d = DSEL_SRAM;
      else if (hsel_apb_i)  dsel_d = DSEL_APB;
      else if (hsel_dma_i)  dsel_d = DSEL_DMA;
      else                  dsel_d = DSEL_DEF;
    end
  end

  // The address phase is accepted only when the current data phase completes,
  // so dsel holds through any number of slave wait states and through ERR1.
  assign dsel_load = hready_o;
  assign load_def  = dsel_load && (dsel_d == DSEL_DEF);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dsel_q <= DSEL_NONE;
    end else if (dsel_load) begin
      dsel_q <= dsel_d;
    end
  end

  // -------------------------------------------------------------------------
  // Default slave: two-cycle ERROR response
  //   ERR1: HREADY=0, HRESP=1  (master sees the error while stalled)
  //   ERR2: HREADY=1, HRESP=1  (completes; next address phase is taken)
  // The response outputs are registered alongside the state so the mux sees
  // clean flop outputs and reset drives them immediately.
  // -------------------------------------------------------------------------
  def_state_e def_state_q;
  logic       def_hready_q;
  logic       def_hresp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      def_state_q  <= DEF_IDLE;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 1'b0;
    end else begin
      unique case (def_state_q)
        DEF_IDLE: begin
          if (load_def) begin
            def_state_q  <= DEF_ERR1;
            def_hready_q <= 1'b0;
            def_hresp_q  <= 1'b1;
          end
        end
        DEF_ERR1: begin
          def_state_q  <= DEF_ERR2;
          def_hready_q <= 1'b1;
          def_hresp_q  <= 1'b1;
        end
        DEF_ERR2: begin
          // HREADY is high here, so dsel reloads on this edge; another
          // unmapped transfer chains straight into ERR1 with no idle cycle.
          if (load_def) begin
            def_state_q  <= DEF_ERR1;
            def_hready_q <= 1'b0;
            def_hresp_q  <= 1'b1;
          end else begin
            def_state_q  <= DEF_IDLE;
            def_hready_q <= 1'b1;
            def_hresp_q  <= 1'b0;
          end
        end
        default: begin
          def_state_q  <= DEF_IDLE;
          def_hready_q <= 1'b1;
          def_hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Data-phase response mux (purely combinational: zero added latency)
  // -------------------------------------------------------------------------
  always_comb begin
    hrdata_o = '0;
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    unique case (dsel_q)
      DSEL_NONE: begin
        hrdata_o = '0;
        hready_o = 1'b1;
        hresp_o  = 1'b0;
      end
      DSEL_ROM: begin
        hrdata_o = hrdata_rom_i;
        hready_o = hreadyout_rom_i;
        hresp_o  = hresp_rom_i;
      end
      DSEL_SRAM: begin
        hrdata_o = hrdata_sram_i;
        hready_o = hreadyout_sram_i;
        hresp_o  = hresp_sram_i;
      end
      DSEL_APB: begin
        hrdata_o = hrdata_apb_i;
        hready_o = hreadyout_apb_i;
        hresp_o  = hresp_apb_i;
      end
      DSEL_DMA: begin
        hrdata_o = hrdata_dma_i;
        hready_o = hreadyout_dma_i;
        hresp_o  = hresp_dma_i;
      end
      DSEL_DEF: begin
        hrdata_o = '0;
        hready_o = def_hready_q;
        hresp_o  = def_hresp_q;
      end
      default: begin
        hrdata_o = '0;
        hready_o = 1'b1;
        hresp_o  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Unmapped-access fault capture
  // -------------------------------------------------------------------------
`ifdef AHB_RESP_MUX_FAULT_CAPTURE_EN
  logic                  err_valid_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  // First unmapped address is sticky. A clear on the same edge as a new
  // unmapped access is treated as clear-then-capture, so capture wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (load_def && (!err_valid_q || err_clr_i)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= haddr_i;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;

  // htrans[0] distinguishes NONSEQ/SEQ and IDLE/BUSY, which this block
  // treats alike.
  logic unused_inputs;
  assign unused_inputs = htrans_i[0];
`else
  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;

  // Without capture, HADDR and err_clr have no consumer.
  logic unused_inputs;
  assign unused_inputs = ^{htrans_i[0], haddr_i, err_clr_i};
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_resp_mux
//
// Self-checking bench for ahb_resp_mux. The driver sets bus inputs just after
// a rising edge and pushes the outputs it expects for that cycle into a
// scoreboard queue; a monitor pops and compares on the falling edge.
// Asynchronous-reset checks are made directly between clock edges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_resp_mux;

  localparam int DW = 32;
  localparam int AW = 32;

`ifdef AHB_RESP_MUX_FAULT_CAPTURE_EN
  localparam logic FC = 1'b1;
`else
  localparam logic FC = 1'b0;
`endif

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  localparam logic [DW-1:0] D_ROM  = 32'h1111_1111;
  localparam logic [DW-1:0] D_SRAM = 32'h3333_3333;
  localparam logic [DW-1:0] D_APB  = 32'h2222_2222;
  localparam logic [DW-1:0] D_DMA  = 32'h4444_4444;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic          hsel_rom, hsel_sram, hsel_apb, hsel_dma;
  logic [DW-1:0] hrdata_rom, hrdata_sram, hrdata_apb, hrdata_dma;
  logic          hrdy_rom, hrdy_sram, hrdy_apb, hrdy_dma;
  logic          hresp_rom, hresp_sram, hresp_apb, hresp_dma;
  logic [DW-1:0] hrdata;
  logic          hready, hresp;
  logic          err_clr;
  logic          err_valid;
  logic [AW-1:0] err_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] rdata;
    logic          rdy;
    logic          resp;
    logic          ev;
    logic [AW-1:0] ea;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  ahb_resp_mux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .htrans_i          (htrans),
    .haddr_i           (haddr),
    .hsel_rom_i        (hsel_rom),
    .hsel_sram_i       (hsel_sram),
    .hsel_apb_i        (hsel_apb),
    .hsel_dma_i        (hsel_dma),
    .hrdata_rom_i      (hrdata_rom),
    .hrdata_sram_i     (hrdata_sram),
    .hrdata_apb_i      (hrdata_apb),
    .hrdata_dma_i      (hrdata_dma),
    .hreadyout_rom_i   (hrdy_rom),
    .hreadyout_sram_i  (hrdy_sram),
    .hreadyout_apb_i   (hrdy_apb),
    .hreadyout_dma_i   (hrdy_dma),
    .hresp_rom_i       (hresp_rom),
    .hresp_sram_i      (hresp_sram),
    .hresp_apb_i       (hresp_apb),
    .hresp_dma_i       (hresp_dma),
    .hrdata_o          (hrdata),
    .hready_o          (hready),
    .hresp_o           (hresp),
    .err_clr_i         (err_clr),
    .err_valid_o       (err_valid),
    .err_addr_o        (err_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Address phase: sel = {dma, apb, sram, rom}
  task automatic addr_phase(input logic [1:0] trans, input logic [AW-1:0] addr,
                            input logic [3:0] sel);
    htrans    = trans;
    haddr     = addr;
    hsel_rom  = sel[0];
    hsel_sram = sel[1];
    hsel_apb  = sel[2];
    hsel_dma  = sel[3];
  endtask

  // Expected outputs for the current cycle; ev/ea are the values a capture
  // build must show and collapse to 0 otherwise.
  task automatic expect_out(input string tag, input logic [DW-1:0] rdata,
                            input logic rdy, input logic resp,
                            input logic ev, input logic [AW-1:0] ea);
    exp_t e;
    e.tag   = tag;
    e.rdata = rdata;
    e.rdy   = rdy;
    e.resp  = resp;
    e.ev    = ev & FC;
    e.ea    = ea & {AW{FC}};
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".hrdata"},    64'(hrdata),    64'(e.rdata));
      check({e.tag, ".hready"},    64'(hready),    64'(e.rdy));
      check({e.tag, ".hresp"},     64'(hresp),     64'(e.resp));
      check({e.tag, ".err_valid"}, 64'(err_valid), 64'(e.ev));
      check({e.tag, ".err_addr"},  64'(err_addr),  64'(e.ea));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    addr_phase(T_IDLE, '0, 4'b0000);
    hrdata_rom = D_ROM;  hrdata_sram = D_SRAM; hrdata_apb = D_APB; hrdata_dma = D_DMA;
    hrdy_rom   = 1'b1;   hrdy_sram   = 1'b1;   hrdy_apb   = 1'b1;  hrdy_dma   = 1'b1;
    hresp_rom  = 1'b0;   hresp_sram  = 1'b0;   hresp_apb  = 1'b0;  hresp_dma  = 1'b0;
    err_clr    = 1'b0;

    // Reset state
    tick();
    tick();
    expect_out("reset", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;

    // Idle after reset release
    expect_out("idle0", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();

    // SRAM read with three wait states; IDLE presented meanwhile must not load
    addr_phase(T_NONSEQ, 32'h2000_0000, 4'b0010);
    expect_out("sram_addr", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    addr_phase(T_IDLE, '0, 4'b0000);
    hrdy_sram   = 1'b0;
    hrdata_sram = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("sram_wait%0d", i), 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    hrdy_sram   = 1'b1;
    hrdata_sram = 32'hCAFE_F00D;
    expect_out("sram_done", 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, '0);
    tick();
    hrdata_sram = D_SRAM;
    expect_out("sram_after", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();

    // Single unmapped access; master drops to IDLE during ERR1
    addr_phase(T_NONSEQ, 32'h7000_0000, 4'b0000);
    expect_out("unm_addr", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    addr_phase(T_IDLE, '0, 4'b0000);
    expect_out("unm_err1", '0, 1'b0, 1'b1, 1'b1, 32'h7000_0000);
    tick();
    expect_out("unm_err2", '0, 1'b1, 1'b1, 1'b1, 32'h7000_0000);
    tick();
    err_clr = 1'b1;
    expect_out("unm_idle", '0, 1'b1, 1'b0, 1'b1, 32'h7000_0000);
    tick();
    err_clr = 1'b0;

    // Back-to-back unmapped accesses
    addr_phase(T_NONSEQ, 32'h7000_0000, 4'b0000);
    expect_out("b2b_addr0", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    addr_phase(T_NONSEQ, 32'h7000_0004, 4'b0000);
    expect_out("b2b_err1a", '0, 1'b0, 1'b1, 1'b1, 32'h7000_0000);
    tick();
    expect_out("b2b_err2a", '0, 1'b1, 1'b1, 1'b1, 32'h7000_0000);
    tick();
    addr_phase(T_IDLE, '0, 4'b0000);
    expect_out("b2b_err1b", '0, 1'b0, 1'b1, 1'b1, 32'h7000_0000);
    tick();
    err_clr = 1'b1;
    expect_out("b2b_err2b", '0, 1'b1, 1'b1, 1'b1, 32'h7000_0000);
    tick();
    err_clr = 1'b0;
    expect_out("b2b_cleared", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();

    // Multiple selects: ROM wins over APB; then DMA two-cycle ERROR passthrough
    addr_phase(T_NONSEQ, 32'h0000_0010, 4'b0101);
    expect_out("prio_addr", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    addr_phase(T_NONSEQ, 32'h4000_0000, 4'b1000);
    expect_out("prio_data", D_ROM, 1'b1, 1'b0, 1'b0, '0);
    tick();
    addr_phase(T_IDLE, '0, 4'b0000);
    hrdy_dma  = 1'b0;
    hresp_dma = 1'b1;
    expect_out("dma_err1", D_DMA, 1'b0, 1'b1, 1'b0, '0);
    tick();
    hrdy_dma  = 1'b1;
    expect_out("dma_err2", D_DMA, 1'b1, 1'b1, 1'b0, '0);
    tick();
    hresp_dma = 1'b0;
    expect_out("dma_after", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();

    // Asynchronous reset asserted in the middle of ERR1
    addr_phase(T_NONSEQ, 32'h7000_0010, 4'b0000);
    expect_out("rst_addr", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    addr_phase(T_IDLE, '0, 4'b0000);
    expect_out("rst_err1", '0, 1'b0, 1'b1, 1'b1, 32'h7000_0010);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.hready",    64'(hready),    64'd1);
    check("async_rst.hresp",     64'(hresp),     64'd0);
    check("async_rst.hrdata",    64'(hrdata),    64'd0);
    check("async_rst.err_valid", 64'(err_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("post_rst", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();

    // Fresh unmapped access after reset must give a clean ERR1/ERR2
    addr_phase(T_NONSEQ, 32'h7000_0020, 4'b0000);
    expect_out("post_addr", '0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    addr_phase(T_IDLE, '0, 4'b0000);
    expect_out("post_err1", '0, 1'b0, 1'b1, 1'b1, 32'h7000_0020);
    tick();
    expect_out("post_err2", '0, 1'b1, 1'b1, 1'b1, 32'h7000_0020);
    tick();
    expect_out("post_idle", '0, 1'b1, 1'b0, 1'b1, 32'h7000_0020);
    tick();
    tick();

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
